// File: rtl/mips_pkg.sv
// Shared fetch-stage types: the NOP word and the queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// fetch_entry_t fixes instr and pc4 at XLEN bits. The fetch queue is built
// with ADDR_W = DATA_W = XLEN.
package mips_pkg;

    localparam int XLEN = 32;

    // NOP: opcode field all ones (6'd63), every other field zero.
    localparam logic [XLEN-1:0] NOP_INSTR = {6'd63, 26'd0};

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue storage: DEPTH x fetch_entry_t.
// Latency: a write is visible at head one cycle after push; reads are combinational.
// Backpressure: none internally. The owner must not push when full; flush empties it.
//
// Ports: clk, rst_n (async, active-low), flush, push/push_entry, pop,
//        head (async read of oldest entry), full, empty, count.
// Pointers carry one extra wrap bit, so count = wr_ptr - rd_ptr modulo 2*DEPTH.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues in-order fetches and buffers responses for IF/ID.
// Latency: rvalid to dec_valid_o is 1 cycle (0 cycles with FETCH_BYPASS_EN and an empty queue).
// Backpressure: dec_ready_i low holds the head; new requests stop once queue + outstanding = DEPTH.
//
// Ports: Clk, Rst (async, active-low); redirect_i/redirect_pc_i from ID;
//        imem_req_o/imem_addr_o/imem_gnt_i and imem_rvalid_i/imem_rdata_i/imem_err_i
//        to instruction memory; dec_valid_o/dec_instr_o/dec_pc4_o/dec_err_o/dec_ready_i to IF/ID.
// Optional feature macro: FETCH_BYPASS_EN (same-cycle response forwarding into an empty queue).
module fetch_prefetch_queue
    import mips_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 redirect_i,
    input  logic [ADDR_W-1:0]    redirect_pc_i,
    output logic                 imem_req_o,
    output logic [ADDR_W-1:0]    imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DATA_W-1:0]    imem_rdata_i,
    input  logic                 imem_err_i,
    output logic                 dec_valid_o,
    output logic [DATA_W-1:0]    dec_instr_o,
    output logic [ADDR_W-1:0]    dec_pc4_o,
    output logic                 dec_err_o,
    input  logic                 dec_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    // Address of the oldest outstanding request; responses return in order.
    logic [ADDR_W-1:0] rsp_addr;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;

    logic              rsp_ok;
    logic              rsp_run;
    logic              issue;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [CW-1:0]     remaining;
    logic [CW:0]       credit_used;

    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // A response with nothing outstanding is spurious and ignored.
    assign rsp_ok      = imem_rvalid_i && (outstanding != '0);
    assign rsp_run     = rsp_ok && (state == ST_RUN) && !redirect_i;
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

    // Rst gates the request so nothing is presented to memory while held in reset.
    assign imem_req_o  = Rst && (state == ST_RUN) && !redirect_i
                         && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign issue       = imem_req_o && imem_gnt_i;

    // Outstanding count left over after this cycle's response retires.
    assign remaining   = outstanding - CW'(rsp_ok);

    assign push_entry.instr = imem_rdata_i;
    assign push_entry.pc4   = rsp_addr + ADDR_W'(4);
    assign push_entry.err   = imem_err_i;

`ifdef FETCH_BYPASS_EN
    // An empty queue forwards the response straight through; it is only
    // stored if IF/ID does not take it this cycle.
    assign bypass = rsp_run && fifo_empty;
    assign push   = rsp_run && !(bypass && dec_ready_i) && !fifo_full;
`else
    assign bypass = 1'b0;
    assign push   = rsp_run && !fifo_full;
`endif

    always_comb begin
        dec_valid_o = 1'b0;
        dec_instr_o = NOP_INSTR;
        dec_pc4_o   = '0;
        dec_err_o   = 1'b0;
        if (bypass) begin
            dec_valid_o = 1'b1;
            dec_instr_o = push_entry.instr;
            dec_pc4_o   = push_entry.pc4;
            dec_err_o   = push_entry.err;
        end else if (!fifo_empty) begin
            dec_valid_o = 1'b1;
            dec_instr_o = head.instr;
            dec_pc4_o   = head.pc4;
            dec_err_o   = head.err;
        end
    end

    // A bypassed word never enters the queue, so only pop a real head.
    // On redirect the flush wins; the popped word is consumed either way.
    assign pop = dec_valid_o && dec_ready_i && !fifo_empty;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (Clk),
        .rst_n      (Rst),
        .flush      (redirect_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            rsp_addr    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
            if (redirect_i) begin
                // Every request still in flight belongs to the old path.
                fetch_pc <= redirect_pc_i;
                rsp_addr <= redirect_pc_i;
                drop_cnt <= remaining;
                state    <= (remaining != '0) ? ST_DRAIN : ST_RUN;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (rsp_run) begin
                    rsp_addr <= rsp_addr + ADDR_W'(4);
                end
                if ((state == ST_DRAIN) && rsp_ok) begin
                    drop_cnt <= drop_cnt - 1'b1;
                    if (drop_cnt == CW'(1)) begin
                        state <= ST_RUN;
                    end
                end
            end
        end
    end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC and memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning queue entries; it is a power of two, 2..16.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port redirect_i, input, 1 bit: branch/jump taken in ID.
REQ-008 The block SHALL have port redirect_pc_i, input, ADDR_W bits: the branch/jump target.
REQ-009 The block SHALL have port imem_req_o, output, 1 bit: fetch request valid.
REQ-010 The block SHALL have port imem_addr_o, output, ADDR_W bits: fetch address.
REQ-011 The block SHALL have port imem_gnt_i, input, 1 bit: request accepted this cycle.
REQ-012 The block SHALL have port imem_rvalid_i, input, 1 bit: response valid.
REQ-013 The block SHALL have port imem_rdata_i, input, DATA_W bits: instruction word.
REQ-014 The block SHALL have port imem_err_i, input, 1 bit: response error (qualified by rvalid).
REQ-015 The block SHALL have port dec_valid_o, output, 1 bit: instruction available to IF/ID.
REQ-016 The block SHALL have port dec_instr_o, output, DATA_W bits: instruction.
REQ-017 The block SHALL have port dec_pc4_o, output, ADDR_W bits: fetch address + 4.
REQ-018 The block SHALL have port dec_err_o, output, 1 bit: fetch error for this instruction.
REQ-019 The block SHALL have port dec_ready_i, input, 1 bit: IF/ID accepts; deasserted on stall.

Function
REQ-020 The block SHALL implement an FSM with states RUN (issue/accept) and DRAIN (discard stale responses, drop_cnt>0).
REQ-021 imem_req_o SHALL be 1 only when state is RUN, redirect_i=0, and (queue count + outstanding) < DEPTH.
REQ-022 On imem_req_o & imem_gnt_i, the fetch PC SHALL advance by 4 (mod 2^ADDR_W, wrap silent) and outstanding SHALL increment.
REQ-023 Responses SHALL be in request order; each rvalid SHALL decrement outstanding and, in RUN, push {rdata, addr+4, err} to the queue.
REQ-024 A handshake SHALL occur when dec_valid_o & dec_ready_i; the head entry pops the same edge.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; pointers carry log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-026 Overflow SHALL be impossible by the credit rule of REQ-021; an rvalid with outstanding=0 SHALL be ignored.
REQ-027 When the queue is empty, dec_valid_o SHALL be 0 and dec_instr_o SHALL be NOP (opcode 6'd63, rest 0), dec_err_o 0.
REQ-028 On redirect_i: the queue SHALL be flushed, the fetch PC SHALL load redirect_pc_i, no request is issued that cycle, any response that cycle is discarded, and drop_cnt SHALL load the remaining outstanding count; the state SHALL be DRAIN if nonzero, else RUN.
REQ-029 In DRAIN, each rvalid SHALL decrement drop_cnt and outstanding without pushing; the state SHALL return to RUN the cycle drop_cnt reaches 0.
REQ-030 A redirect during DRAIN SHALL reload drop_cnt from outstanding per REQ-028.
REQ-031 A redirect SHALL take priority over a same-cycle dec handshake; the popped instruction is still consumed.

Reset
REQ-032 While Rst=0, the block SHALL set fetch PC=RESET_PC, the queue empty, outstanding=0, drop_cnt=0, state RUN, imem_req_o=0, dec_valid_o=0, dec_instr_o=NOP, dec_pc4_o=0, and dec_err_o=0.
REQ-033 Reset mid-transaction SHALL abandon all outstanding requests; the memory is reset together with this block.

Configuration
REQ-034 With FETCH_BYPASS_EN defined, an rvalid in RUN with the queue empty SHALL drive dec_* combinationally the same cycle, and is not stored if dec_ready_i=1.
REQ-035 Without FETCH_BYPASS_EN, responses SHALL always be stored first; the minimum rvalid-to-dec_valid_o latency is 1 cycle.

Structure
REQ-036 The shared package mips_pkg SHALL hold the NOP_INSTR constant and the fetch_entry_t typedef {instr, pc4, err}.
REQ-037 Queue storage SHALL be a sub-module fetch_fifo (DEPTH x fetch_entry_t, sync write, async read, full/empty/count).

Verification
REQ-038 The bench SHALL cover: Rst released, gnt=1, and memory with 1-cycle rvalid -> addresses 0,4,8,12 issued and dec_pc4_o 4,8,12,16 in order.
REQ-039 The bench SHALL cover: dec_ready_i=0, DEPTH=4 -> exactly 4 grants then imem_req_o=0; ready=1 for one cycle -> one further request.
REQ-040 The bench SHALL cover: 3 outstanding and redirect_i with target 0x100 -> 3 responses dropped, state DRAIN, then the first dec_pc4_o is 0x104.
REQ-041 The bench SHALL cover: a second redirect to 0x200 during DRAIN -> drop_cnt reload, and only 0x200+ instructions delivered.
REQ-042 The bench SHALL cover: imem_err_i=1 on the response to 0x8 -> dec_err_o=1 with dec_pc4_o=0xC, and fetch continuing.
REQ-043 The bench SHALL cover: with FETCH_BYPASS_EN, an empty queue, and rvalid -> dec_valid_o in the same cycle; without the macro -> the following cycle.
